serial_cmp_ctrl: RTL and testbench

Bit-serial magnitude comparator controller for the mini-ALU. It captures two WIDTH-bit operands on a start request and scans them MSB-first, one bit per clock, through a single 1-bit equality cell. It stops at the first differing bit and reports exactly one of less-than, equal or greater-than with a done pulse. It trades latency for area next to the combinational compare path and is sequenced by the ALU top-level through a start/busy/done handshake.

---
 rtl/serial_cmp_ctrl_pkg.sv | 17 +
 rtl/serial_cmp_ctrl_bit_eq.sv | 10 +
 rtl/serial_cmp_ctrl.sv | 96 +++++++++
 tb/tb_serial_cmp_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared types for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_LT   = 2'd1,
    RES_EQ   = 2'd2,
    RES_GT   = 2'd3
  } result_t;

endpackage

// File: rtl/serial_cmp_ctrl_bit_eq.sv
// Single-bit equality cell shared by every step of the serial scan.
module bit_eq (
  input  logic i0,
  input  logic i1,
  output logic eq
);

  assign eq = ~(i0 ^ i1);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: scans operands MSB-first and
// stops at the first differing bit.
//
// state | meaning
// IDLE  | waiting for start; last result held on the flags
// SCAN  | comparing sa/sb MSBs, one bit per clock
// DONE  | done pulse cycle, result valid
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [CW-1:0]    cycles
);

  state_t           state;
  result_t          res;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    idx;
  logic             bit_same;

  bit_eq u_bit_eq (
    .i0 (sa[WIDTH-1]),
    .i1 (sb[WIDTH-1]),
    .eq (bit_same)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      res    <= RES_NONE;
      sa     <= '0;
      sb     <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            idx    <= CW'(WIDTH - 1);
            res    <= RES_NONE;
            cycles <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (!bit_same) begin
            // the first differing bit decides: A holding the 1 is the larger
            res    <= sa[WIDTH-1] ? RES_GT : RES_LT;
            cycles <= CW'(WIDTH) - idx;
            done   <= 1'b1;
            state  <= DONE;
          end else if (idx == '0) begin
            res    <= RES_EQ;
            cycles <= CW'(WIDTH);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // flags decode from one result register, so they are one-hot by construction
  assign a_lt_b = (res == RES_LT);
  assign a_eq_b = (res == RES_EQ);
  assign a_gt_b = (res == RES_GT);

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench for serial_cmp_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_cmp_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, lt8, eq8, gt8;
  logic       busy1, done1, lt1, eq1, gt1;
  logic [3:0] cycles8;
  logic [0:0] cycles1;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  serial_cmp_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .a_lt_b(lt8), .a_eq_b(eq8), .a_gt_b(gt8),
    .cycles(cycles8)
  );

  serial_cmp_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .a_lt_b(lt1), .a_eq_b(eq1), .a_gt_b(gt1),
    .cycles(cycles1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       o_busy, o_done;
  logic [2:0] o_flags;
  logic [3:0] o_cyc;
  assign o_busy  = sel ? busy1 : busy8;
  assign o_done  = sel ? done1 : done8;
  assign o_flags = sel ? {lt1, eq1, gt1} : {lt8, eq8, gt8};
  assign o_cyc   = sel ? {3'b0, cycles1} : cycles8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags expected as {lt, eq, gt}
  task automatic run_cmp(input string tag, input bit w1, input logic [7:0] av,
                         input logic [7:0] bv, input logic [2:0] exp_flags,
                         input int exp_cyc);
    int  n;
    bit  seen;
    bit  stray;
    sel = w1;
    if (w1) begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; end
    else    begin start8 = 1'b1; a8 = av;    b8 = bv;    end
    tick();
    start1 = 1'b0;
    start8 = 1'b0;
    check({tag, ".busy_e0"}, o_busy, 1);
    check({tag, ".flags_e0"}, o_flags, 3'b000);
    n = 0;
    seen = 1'b0;
    stray = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (o_done) seen = 1'b1;
      else if (o_flags != 3'b000) stray = 1'b1;
    end
    check({tag, ".done_seen"}, seen, 1);
    check({tag, ".latency"}, n, exp_cyc);
    check({tag, ".no_early_flags"}, stray, 0);
    check({tag, ".flags"}, o_flags, exp_flags);
    check({tag, ".cycles"}, o_cyc, exp_cyc);
    tick();
    check({tag, ".done_end"}, o_done, 0);
    check({tag, ".busy_end"}, o_busy, 0);
    check({tag, ".flags_hold"}, o_flags, exp_flags);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    #2;
    check("rst.busy", busy8, 0);
    check("rst.done", done8, 0);
    check("rst.flags", {lt8, eq8, gt8}, 3'b000);
    check("rst.cycles", cycles8, 0);
    #10 rst_n = 1'b1;
    tick();

    run_cmp("gt_msb", 1'b0, 8'h80, 8'h7F, 3'b001, 1);
    run_cmp("eq_5a", 1'b0, 8'h5A, 8'h5A, 3'b010, 8);
    run_cmp("lt_lsb", 1'b0, 8'h12, 8'h13, 3'b100, 8);
    run_cmp("gt_lsb", 1'b0, 8'h13, 8'h12, 3'b001, 8);

    // start during SCAN ignored, then start held high re-accepts in IDLE
    sel = 1'b0;
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h40;
    tick();
    a8 = 8'hFF;
    tick();
    check("ign.done_e1", done8, 0);
    check("ign.flags_e1", {lt8, eq8, gt8}, 3'b000);
    tick();
    check("ign.done_e2", done8, 1);
    check("ign.flags_e2", {lt8, eq8, gt8}, 3'b100);
    check("ign.cycles_e2", cycles8, 2);
    tick();
    check("ign.busy_e3", busy8, 0);
    check("ign.done_e3", done8, 0);
    tick();
    start8 = 1'b0;
    check("held.busy", busy8, 1);
    check("held.flags_clr", {lt8, eq8, gt8}, 3'b000);
    tick();
    check("held.done", done8, 1);
    check("held.flags", {lt8, eq8, gt8}, 3'b001);
    check("held.cycles", cycles8, 1);
    tick();

    // asynchronous reset in mid-scan
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy", busy8, 0);
    check("arst.done", done8, 0);
    check("arst.flags", {lt8, eq8, gt8}, 3'b000);
    check("arst.cycles", cycles8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst.no_done", done8, 0);
    run_cmp("post_rst", 1'b0, 8'h03, 8'h01, 3'b001, 7);

    run_cmp("w1_lt", 1'b1, 8'h00, 8'h01, 3'b100, 1);
    run_cmp("w1_eq", 1'b1, 8'h01, 8'h01, 3'b010, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
